// File: rtl/hex_display_sched.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_sched
// Purpose  : Scans DIGITS nibbles through one shared external hex decoder and
//            commits every glyph to HEX0..HEX7 in a single edge.
//            Optional macro BLANK_LEADING_ZERO_EN blanks leading-zero digits.
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_sched #(
    parameter int DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    output logic [3:0]  nib_out,
    input  logic [6:0]  seg_in,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7,
    output logic        done
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_SCAN      = 2'd1;
    localparam logic [1:0] S_COMMIT    = 2'd2;
    localparam logic [6:0] GLYPH_ZERO  = 7'b1000000;
    localparam logic [2:0] LAST_IDX    = 3'(DIGITS - 1);
`ifdef BLANK_LEADING_ZERO_EN
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
`endif

    logic [1:0]  state_q, state_d;
    logic [31:0] value_q, value_d;
    logic [2:0]  idx_q, idx_d;
    logic        done_q, done_d;
    logic [6:0]  shadow_q [8];
    logic [6:0]  shadow_d [8];
    logic [6:0]  hex_q [8];
    logic [6:0]  hex_d [8];
    logic        transfer;

    assign transfer = load_valid & load_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (transfer) state_d = S_SCAN;
            S_SCAN:   if (idx_q == LAST_IDX) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        load_ready = (state_q == S_IDLE);
        nib_out    = 4'h0;
        if (state_q == S_SCAN) begin
            nib_out = value_q[{idx_q, 2'b00} +: 4];
        end
    end

    // Datapath: capture, scan into shadow, commit shadow to the displays
    always_comb begin
`ifdef BLANK_LEADING_ZERO_EN
        logic lead_zero;
        lead_zero = 1'b1;
`endif
        value_d  = value_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        shadow_d = shadow_q;
        hex_d    = hex_q;
        if (transfer) begin
            value_d = load_data;
            idx_d   = 3'd0;
        end
        if (state_q == S_SCAN) begin
            shadow_d[idx_q] = seg_in;
            idx_d           = idx_q + 3'd1;
        end
        if (state_q == S_COMMIT) begin
            done_d = 1'b1;
            idx_d  = 3'd0;
            // Walk from the most significant scanned digit so the zero run is known
            for (int k = DIGITS - 1; k >= 0; k--) begin
                hex_d[k] = shadow_q[k];
`ifdef BLANK_LEADING_ZERO_EN
                lead_zero = lead_zero & (value_q[4*k +: 4] == 4'h0);
                if ((k != 0) && lead_zero) begin
                    hex_d[k] = GLYPH_BLANK;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                shadow_q[k] <= GLYPH_ZERO;
                hex_q[k]    <= GLYPH_ZERO;
            end
        end else begin
            value_q  <= value_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            shadow_q <= shadow_d;
            hex_q    <= hex_d;
        end
    end

    assign done = done_q;
    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];
    assign HEX6 = hex_q[6];
    assign HEX7 = hex_q[7];

endmodule
`default_nettype wire

// File: tb/tb_hex_display_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_sched
// Purpose  : Directed scoreboard bench for hex_display_sched (DIGITS 8 and 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_display_sched;

    localparam logic [55:0] RESET_HEX = {8{7'b1000000}};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lv = 1'b0;
    logic [31:0] ld = '0;
    bit          sel = 1'b0;

    logic        valid_a, ready_a, done_a, valid_b, ready_b, done_b;
    logic [3:0]  nib_a, nib_b;
    logic [6:0]  seg_a, seg_b;
    logic [6:0]  a0, a1, a2, a3, a4, a5, a6, a7;
    logic [6:0]  b0, b1, b2, b3, b4, b5, b6, b7;
    logic [55:0] hex_a, hex_b;

    logic        obs_ready, obs_done;
    logic [3:0]  obs_nib;
    logic [55:0] obs_hex;

    int          errors = 0;
    int          checks = 0;
    logic [55:0] exp_q [$];
    logic [55:0] prev_a = RESET_HEX;
    logic [55:0] prev_b = RESET_HEX;

    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [55:0] model(input logic [31:0] v, input int d);
        logic [55:0] r;
        logic [6:0]  g;
        logic        lz;
        r  = '0;
        lz = 1'b1;
        for (int k = 7; k >= 0; k--) begin
            if (k < d) begin
                lz = lz && (v[4*k +: 4] == 4'h0);
                g  = dec(v[4*k +: 4]);
`ifdef BLANK_LEADING_ZERO_EN
                if (k > 0 && lz) g = 7'b1111111;
`endif
            end else begin
                g = 7'b1000000;
            end
            r[7*k +: 7] = g;
        end
        return r;
    endfunction

    assign valid_a = lv & ~sel;
    assign valid_b = lv & sel;
    assign seg_a   = dec(nib_a);
    assign seg_b   = dec(nib_b);
    assign hex_a   = {a7, a6, a5, a4, a3, a2, a1, a0};
    assign hex_b   = {b7, b6, b5, b4, b3, b2, b1, b0};

    always_comb begin
        obs_ready = sel ? ready_b : ready_a;
        obs_done  = sel ? done_b  : done_a;
        obs_nib   = sel ? nib_b   : nib_a;
        obs_hex   = sel ? hex_b   : hex_a;
    end

    hex_display_sched #(.DIGITS(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .load_valid(valid_a), .load_ready(ready_a),
        .load_data(ld), .nib_out(nib_a), .seg_in(seg_a),
        .HEX0(a0), .HEX1(a1), .HEX2(a2), .HEX3(a3),
        .HEX4(a4), .HEX5(a5), .HEX6(a6), .HEX7(a7), .done(done_a)
    );

    hex_display_sched #(.DIGITS(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .load_valid(valid_b), .load_ready(ready_b),
        .load_data(ld), .nib_out(nib_b), .seg_in(seg_b),
        .HEX0(b0), .HEX1(b1), .HEX2(b2), .HEX3(b3),
        .HEX4(b4), .HEX5(b5), .HEX6(b6), .HEX7(b7), .done(done_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer a value and wait (bounded) for the transfer edge; expected glyphs join the scoreboard
    task automatic start(input bit s, input logic [31:0] v);
        int n;
        n = 0;
        @(negedge clk);
        sel = s;
        lv  = 1'b1;
        ld  = v;
        while (!obs_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_xfer", 64'(obs_ready), 64'd1);
        @(posedge clk);
        exp_q.push_back(model(v, s ? 4 : 8));
    endtask

    // Follow one update from the cycle after transfer through the done pulse
    task automatic track(input logic [31:0] v, input bit hold, input logic [31:0] hold_data);
        int          d;
        bit          seen;
        logic [55:0] prev, exp;
        d    = sel ? 4 : 8;
        prev = sel ? prev_b : prev_a;
        seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                lv = hold;
                ld = hold ? hold_data : $urandom;
            end else if (!hold) begin
                ld = $urandom;
            end
            if (obs_done) begin
                seen = 1'b1;
                chk("done_latency", 64'(i), 64'(d + 2));
                chk("ready_in_done", 64'(obs_ready), 64'd1);
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 64'd1, 64'd0);
                end else begin
                    exp = exp_q.pop_front();
                    chk("hex_commit", 64'(obs_hex), 64'(exp));
                    if (sel) prev_b = exp; else prev_a = exp;
                end
                break;
            end
            chk("ready_busy", 64'(obs_ready), 64'd0);
            chk("hex_hold_busy", 64'(obs_hex), 64'(prev));
            if (i <= d) chk("nib_scan", 64'(obs_nib), 64'(v[4*(i-1) +: 4]));
            else        chk("nib_commit", 64'(obs_nib), 64'd0);
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
        if (!hold) begin
            @(negedge clk);
            chk("done_one_cycle", 64'(obs_done), 64'd0);
        end
    endtask

    initial begin
        int pulses;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_hex_a", 64'(hex_a), 64'(RESET_HEX));
        chk("rst_hex_b", 64'(hex_b), 64'(RESET_HEX));
        chk("rst_ready", 64'({ready_a, ready_b}), 64'd3);
        chk("rst_done",  64'({done_a, done_b}), 64'd0);
        chk("rst_nib",   64'({nib_a, nib_b}), 64'd0);
        rst_n = 1'b1;

        // All-zero value, then a mixed value with explicit glyph spot checks
        start(1'b0, 32'h0000_0000);
        track(32'h0000_0000, 1'b0, '0);
        start(1'b0, 32'h7D5C_A3F1);
        track(32'h7D5C_A3F1, 1'b0, '0);
        chk("hex0_7D5C", 64'(a0), 64'(7'b1111001));
        chk("hex1_7D5C", 64'(a1), 64'(7'b0001110));
        chk("hex7_7D5C", 64'(a7), 64'(7'b1111000));

        // Second request held during a scan transfers right after done
        start(1'b0, 32'h1234_5678);
        track(32'h1234_5678, 1'b1, 32'h9ABC_DEF0);
        @(posedge clk);
        exp_q.push_back(model(32'h9ABC_DEF0, 8));
        track(32'h9ABC_DEF0, 1'b0, '0);

        // Leading-zero pattern
        start(1'b0, 32'h0000_0A50);
        track(32'h0000_0A50, 1'b0, '0);
`ifdef BLANK_LEADING_ZERO_EN
        chk("lz_hex", 64'(hex_a), 64'({{5{7'b1111111}}, 7'b0001000, 7'b0010010, 7'b1000000}));
`else
        chk("lz_hex", 64'(hex_a), 64'({{5{7'b1000000}}, 7'b0001000, 7'b0010010, 7'b1000000}));
`endif

        // Idle with wiggling data and no valid
        repeat (6) begin
            @(negedge clk);
            ld = $urandom;
        end
        chk("idle_hold_hex", 64'(hex_a), 64'(prev_a));
        chk("idle_nib", 64'(nib_a), 64'd0);

        // Reset in mid-scan (idx 4)
        start(1'b0, 32'hFFFF_FFFF);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) lv = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_hex", 64'(hex_a), 64'(RESET_HEX));
        chk("midrst_ready", 64'(ready_a), 64'd1);
        chk("midrst_nib", 64'(nib_a), 64'd0);
        chk("midrst_done", 64'(done_a), 64'd0);
        exp_q.delete();
        prev_a = RESET_HEX;
        prev_b = RESET_HEX;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_a) pulses++;
        end
        chk("midrst_no_done", 64'(pulses), 64'd0);
        chk("midrst_hex_after", 64'(hex_a), 64'(RESET_HEX));

        // Four-digit instance
        start(1'b1, 32'hFFFF_1234);
        track(32'hFFFF_1234, 1'b0, '0);
        chk("d4_hex", 64'(hex_b),
            64'({{4{7'b1000000}}, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}));
        chk("d4_other_idle", 64'(hex_a), 64'(RESET_HEX));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hex_display_sched.md
HEX_DISPLAY_SCHED -- requirements
Module: hex_display_sched

Interface
REQ-001 SHALL have parameter: DIGITS, 8, number of digits scanned (legal 1..8); HEXn with n >= DIGITS held at reset glyph.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: load_valid  input  1  requester offers a new 32-bit display value.
REQ-005 SHALL have port: load_ready  output  1  block accepts load_data this cycle.
REQ-006 SHALL have port: load_data  input  32  value; nibble k drives digit k; bits at and above 4*DIGITS ignored.
REQ-007 SHALL have port: nib_out  output  4  nibble presented to the shared external hex decoder.
REQ-008 SHALL have port: seg_in  input  7  decoder result for nib_out, combinational, active-low segments.
REQ-009 SHALL have ports: HEX0..HEX7  output  7 each  registered active-low segment patterns.
REQ-010 SHALL have port: done  output  1  one-cycle pulse after the displays are updated.

Function
REQ-011 SHALL implement FSM states IDLE, SCAN, COMMIT.
REQ-012 SHALL drive load_ready = 1 only in IDLE; a transfer occurs on an edge with load_valid & load_ready.
REQ-013 On transfer SHALL capture load_data into an internal value register, set digit index to 0, and enter SCAN.
REQ-014 In SCAN SHALL drive nib_out = value[4*idx+3 : 4*idx] and capture seg_in into shadow[idx] at each edge.
REQ-015 SHALL increment idx each SCAN edge; the edge capturing idx = DIGITS-1 SHALL enter COMMIT.
REQ-016 Outside SCAN SHALL drive nib_out = 4'h0.
REQ-017 At the COMMIT edge SHALL load all HEX0..HEX(DIGITS-1) from shadow simultaneously (no partially updated display visible), set done = 1 for the following cycle, and enter IDLE.
REQ-018 Latency: transfer edge E0, SCAN edges E1..E(DIGITS), COMMIT edge E(DIGITS+1); HEX valid and done high in the cycle after E(DIGITS+1); next transfer no earlier than E(DIGITS+2) (10 cycles per update at DIGITS = 8).
REQ-019 load_valid while load_ready = 0 SHALL be ignored; the requester holds load_valid and load_data until transfer.
REQ-020 load_valid asserted in the cycle done is high SHALL transfer on that edge (back-to-back updates).
REQ-021 HEX outputs SHALL hold their last committed values indefinitely while IDLE.
REQ-022 Changes on load_data when no transfer occurs SHALL not affect nib_out or HEX.

Reset
REQ-023 rst_n low SHALL immediately, without a clock, force: state IDLE, idx 0, load_ready 1, done 0, nib_out 0, shadow and HEX0..HEX7 = 7'b1000000 (glyph "0").
REQ-024 Reset during SCAN or COMMIT SHALL abort the update; no shadow content reaches HEX; first transfer possible on the first edge after rst_n rises.

Configuration
REQ-025 Macro BLANK_LEADING_ZERO_EN defined: at COMMIT, each digit k > 0 whose nibble and all higher scanned nibbles are 0 SHALL be committed as 7'b1111111 (blank); digit 0 SHALL never blank.
REQ-026 Macro BLANK_LEADING_ZERO_EN undefined: every scanned digit SHALL show its decoded glyph, including leading zeros.

Verification
REQ-027 Reset, then transfer 32'h0000_0000 -> 10 cycles later done = 1 for 1 cycle; HEX0..HEX7 = 7'b1000000 (macro off), or HEX0 = 7'b1000000 and HEX1..HEX7 = 7'b1111111 (macro on).
REQ-028 Transfer 32'h7D5C_A3F1 -> nib_out sequence 1,F,3,A,C,5,D,7 on consecutive SCAN cycles; after commit HEX0 = 7'b1111001, HEX1 = 7'b0001110, HEX7 = 7'b1111000.
REQ-029 Hold load_valid high with a new value during SCAN -> load_ready = 0, HEX unchanged until the first commit; the second value transfers on the edge after done.
REQ-030 Transfer 32'h0000_0A50 with macro on -> HEX0 = 7'b1000000, HEX1 = 7'b0010010, HEX2 = 7'b0001000, HEX3..HEX7 = 7'b1111111.
REQ-031 Assert rst_n = 0 at SCAN idx = 4 after transfer of 32'hFFFF_FFFF -> HEX0..HEX7 = 7'b1000000 immediately, done never pulses, load_ready = 1.
REQ-032 DIGITS = 4, transfer 32'hFFFF_1234 -> done 6 cycles after transfer; HEX0..HEX3 show 4,3,2,1; HEX4..HEX7 = 7'b1000000.
